drv_spi_slave_unit: RTL

Synthesizable SPI target that emulates the DRV8320S register interface on the 16-bit, MSB-first frame the gate-driver SPI master produces. Oversamples nSCS/SCLK/SDI on sys_clk and decodes R/W, address and data. Serves a 7-entry register file and returns read data on SDO. Sits on the FPGA side of the gate-driver SPI pins for closed-loop emulation and board bring-up without a driver IC fitted.

---
 rtl/drv_spi_slave_unit_pkg.sv | 38 +++
 rtl/drv_spi_slave_unit_if.sv | 18 +
 rtl/drv_spi_slave_unit_spi_edge_sync.sv | 32 +++
 rtl/drv_spi_slave_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/drv_spi_slave_unit_pkg.sv
// Shared constants, reset defaults and FSM encoding for the DRV8320S-style SPI target.
// Register map: 0/1 read-only status, 2..6 control, 7 optional error counter.
package drv_spi_slave_unit_pkg;

  localparam int FRAME_WIDTH    = 16;
  localparam int ADDR_WIDTH     = 4;
  localparam int REG_DATA_WIDTH = 11;
  localparam int NUM_CTRL       = 5;

  localparam logic [4:0] CNT_SNAP = 5'd4;
  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_SAT  = 5'd17;

  localparam logic [ADDR_WIDTH-1:0] ADDR_FAULT   = 4'd0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_VGS     = 4'd1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL_LO = 4'd2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL_HI = 4'd6;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ERRCNT  = 4'd7;

  // Address 6 in the top slice down to address 2 in the bottom slice.
  localparam logic [NUM_CTRL*REG_DATA_WIDTH-1:0] CTRL_DEFAULTS =
    {11'h283, 11'h159, 11'h7FF, 11'h3FF, 11'h000};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } spi_state_e;

  function automatic logic is_ctrl_addr(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >= ADDR_CTRL_LO) && (addr <= ADDR_CTRL_HI);
  endfunction

  function automatic logic [2:0] ctrl_index(input logic [ADDR_WIDTH-1:0] addr);
    return 3'(addr - ADDR_CTRL_LO);
  endfunction

endpackage

// File: rtl/drv_spi_slave_unit_if.sv
// Gate-driver SPI pin bundle; slave modport is the FPGA target side, master the bus owner.
interface drv_spi_slave_unit_if;
  logic spi_nscs_in;
  logic spi_sclk_in;
  logic spi_sdi_in;
  logic spi_sdo_out;
  logic spi_sdo_oe_out;

  modport slave (
    input  spi_nscs_in, spi_sclk_in, spi_sdi_in,
    output spi_sdo_out, spi_sdo_oe_out
  );

  modport master (
    output spi_nscs_in, spi_sclk_in, spi_sdi_in,
    input  spi_sdo_out, spi_sdo_oe_out
  );
endinterface

// File: rtl/drv_spi_slave_unit_spi_edge_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin with single-cycle rise/fall pulses.
module drv_spi_slave_unit_spi_edge_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/drv_spi_slave_unit.sv
// DRV8320S register-interface emulator: 16-bit MSB-first SPI target with a 7-entry register file.
// Optional DRV_SPI_FRAME_ERR_EN adds frame_error_out pulses and a saturating error counter at address 7.
module drv_spi_slave_unit
  import drv_spi_slave_unit_pkg::*;
(
  input  logic                               sys_clk,
  input  logic                               reset_n,
  drv_spi_slave_unit_if.slave                spi,
  input  logic [REG_DATA_WIDTH-1:0]          fault_status_in,
  input  logic [REG_DATA_WIDTH-1:0]          vgs_status_in,
  output logic [NUM_CTRL*REG_DATA_WIDTH-1:0] ctrl_regs_out,
  output logic                               frame_done_out,
  output logic                               frame_wr_out,
  output logic [ADDR_WIDTH-1:0]              frame_addr_out,
  output logic                               frame_error_out
);

  logic w_sclk_rise, w_sclk_fall, w_nscs_rise, w_nscs_fall;
  logic r_sdi_meta, r_sdi_sync;
  spi_state_e r_state, w_state_nxt;
  logic w_frame_start;
  logic [4:0] r_cnt;
  logic [FRAME_WIDTH-1:0] r_shift;
  logic [REG_DATA_WIDTH-1:0] r_snap, w_rd_data;
  logic [FRAME_WIDTH-1:0] w_resp;
  logic [3:0] w_bit_sel;
  logic [ADDR_WIDTH-1:0] w_addr_in;
  logic w_snap_take, w_frame_ok, w_wr_hit;
  logic r_sdo, r_oe, r_done, r_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NUM_CTRL-1:0][REG_DATA_WIDTH-1:0] r_ctrl;

  drv_spi_slave_unit_spi_edge_sync #(.RESET_VAL(1'b0)) u_sclk_sync (
    .sys_clk(sys_clk), .reset_n(reset_n), .i_async(spi.spi_sclk_in),
    .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  drv_spi_slave_unit_spi_edge_sync #(.RESET_VAL(1'b1)) u_nscs_sync (
    .sys_clk(sys_clk), .reset_n(reset_n), .i_async(spi.spi_nscs_in),
    .o_rise(w_nscs_rise), .o_fall(w_nscs_fall)
  );

  // SDI only needs to be aligned with the synchronized SCLK, no edges.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sdi_meta <= 1'b0;
      r_sdi_sync <= 1'b0;
    end else begin
      r_sdi_meta <= spi.spi_sdi_in;
      r_sdi_sync <= r_sdi_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state; a chip-select fall seen during COMMIT starts the next frame directly.
  always_comb begin
    w_state_nxt   = r_state;
    w_frame_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_nscs_fall) begin
          w_state_nxt   = ST_SHIFT;
          w_frame_start = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_nscs_rise) w_state_nxt = ST_COMMIT;
        else             w_state_nxt = ST_SHIFT;
      end
      ST_COMMIT: begin
        if (w_nscs_fall) begin
          w_state_nxt   = ST_SHIFT;
          w_frame_start = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_frame_ok  = (r_state == ST_COMMIT) && (r_cnt == CNT_FULL);
  assign w_wr_hit    = w_frame_ok && !r_shift[15] && is_ctrl_addr(r_shift[14:11]);
  // On the 5th falling edge the address is three shifted bits plus the bit on the wire now.
  assign w_addr_in   = {r_shift[2:0], r_sdi_sync};
  assign w_snap_take = (r_state == ST_SHIFT) && w_sclk_fall && (r_cnt == CNT_SNAP);
  assign w_resp      = {5'b00000, r_snap};
  assign w_bit_sel   = 4'd15 - r_cnt[3:0];

`ifdef DRV_SPI_FRAME_ERR_EN
  logic [7:0] r_err_cnt;
  logic       r_err;
  logic       w_frame_bad;

  assign w_frame_bad = (r_state == ST_COMMIT) && (r_cnt != CNT_FULL);

  // Error pulse and saturating error counter.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_err <= w_frame_bad;
      if (w_frame_bad && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_error_out = r_err;
`else
  assign frame_error_out = 1'b0;
`endif

  // Read mux evaluated at snapshot time.
  always_comb begin
    w_rd_data = 11'h000;
    case (w_addr_in)
      ADDR_FAULT: w_rd_data = fault_status_in;
      ADDR_VGS:   w_rd_data = vgs_status_in;
      ADDR_ERRCNT: begin
`ifdef DRV_SPI_FRAME_ERR_EN
        w_rd_data = {3'b000, r_err_cnt};
`else
        w_rd_data = 11'h000;
`endif
      end
      default: begin
        if (is_ctrl_addr(w_addr_in)) w_rd_data = r_ctrl[ctrl_index(w_addr_in)];
        else                         w_rd_data = 11'h000;
      end
    endcase
  end

  // Falling-edge sampler and saturating bit counter.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= 5'd0;
      r_shift <= 16'h0000;
    end else if (w_frame_start) begin
      r_cnt   <= 5'd0;
      r_shift <= 16'h0000;
    end else if ((r_state == ST_SHIFT) && w_sclk_fall) begin
      r_shift <= {r_shift[FRAME_WIDTH-2:0], r_sdi_sync};
      if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 5'd1;
    end
  end

  // Response snapshot and SDO launch on rising edges 2..16; SDO parks at 0 outside a frame.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= 11'h000;
      r_sdo  <= 1'b0;
    end else begin
      if (w_snap_take) r_snap <= w_rd_data;
      if ((r_state == ST_SHIFT) && !w_nscs_rise) begin
        if (w_sclk_rise && (r_cnt != 5'd0) && (r_cnt < CNT_FULL)) r_sdo <= w_resp[w_bit_sel];
      end else begin
        r_sdo <= 1'b0;
      end
    end
  end

  // Output enable follows the synchronized chip select.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)         r_oe <= 1'b0;
    else if (w_nscs_fall) r_oe <= 1'b1;
    else if (w_nscs_rise) r_oe <= 1'b0;
  end

  // Control register file.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)      r_ctrl <= CTRL_DEFAULTS;
    else if (w_wr_hit) r_ctrl[ctrl_index(r_shift[14:11])] <= r_shift[10:0];
  end

  // Frame status reporting.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_done <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= 4'h0;
    end else begin
      r_done <= w_frame_ok;
      if (w_frame_ok) begin
        r_wr   <= ~r_shift[15];
        r_addr <= r_shift[14:11];
      end
    end
  end

  assign spi.spi_sdo_out    = r_sdo;
  assign spi.spi_sdo_oe_out = r_oe;
  assign ctrl_regs_out      = r_ctrl;
  assign frame_done_out     = r_done;
  assign frame_wr_out       = r_wr;
  assign frame_addr_out     = r_addr;

endmodule
